w_stage_grf: RTL and testbench

General-purpose register file and write-back commit point of the five-stage MIPS pipeline. It consumes the W-stage destination register number produced by the W-stage RegDst selector, together with the write-back data, PC and valid bit. It serves the two D-stage read ports. It also emits a registered one-cycle commit trace used by the simulation harness for retirement checking.

---
 rtl/w_stage_grf_pkg.sv | 17 +
 rtl/w_stage_grf_commit_trace.sv | 40 ++++
 rtl/w_stage_grf.sv | 82 ++++++++
 tb/tb_w_stage_grf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/w_stage_grf_pkg.sv
// Shared constants and the commit-trace payload type for the W-stage register file.
package w_stage_grf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned PC_W       = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [PC_W-1:0]       pc;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } commit_trace_t;

endpackage

// File: rtl/w_stage_grf_commit_trace.sv
// Registered one-cycle commit trace; payload holds its last value when nothing commits.
module grf_commit_trace
    import w_stage_grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              t_valid,
    output logic [PC_W-1:0]   t_pc,
    output logic [ADDR_W-1:0] t_addr,
    output logic [DATA_W-1:0] t_data
);

    commit_trace_t trace_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_q <= '0;
        end else begin
            trace_q.valid <= we;
            if (we) begin
                trace_q.pc   <= pc;
                trace_q.addr <= ADDR_W_DEF'(addr);
                trace_q.data <= DATA_W_DEF'(data);
            end
        end
    end

    assign t_valid = trace_q.valid;
    assign t_pc    = trace_q.pc;
    assign t_addr  = ADDR_W'(trace_q.addr);
    assign t_data  = DATA_W'(trace_q.data);

endmodule

// File: rtl/w_stage_grf.sv
// General-purpose register file and write-back commit point of the MIPS pipeline.
// Define GRF_BYPASS_EN to forward same-cycle write data to the read ports.
module w_stage_grf
    import w_stage_grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_A1,
    input  logic [ADDR_W-1:0] D_A2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    input  logic [ADDR_W-1:0] W_A3,
    input  logic [DATA_W-1:0] W_WD,
    input  logic [PC_W-1:0]   W_PC,
    input  logic              W_Valid,
    output logic              T_Valid,
    output logic [PC_W-1:0]   T_PC,
    output logic [ADDR_W-1:0] T_Addr,
    output logic [DATA_W-1:0] T_Data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              we;

    assign we = W_Valid && (W_A3 != ADDR_W'(REG_ZERO));

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[W_A3] <= W_WD;
        end
    end

    always_comb begin
        D_RD1 = '0;
        if (D_A1 != ADDR_W'(REG_ZERO)) begin
            D_RD1 = regs[D_A1];
        end
`ifdef GRF_BYPASS_EN
        if (we && (D_A1 == W_A3)) begin
            D_RD1 = W_WD;
        end
`endif
    end

    always_comb begin
        D_RD2 = '0;
        if (D_A2 != ADDR_W'(REG_ZERO)) begin
            D_RD2 = regs[D_A2];
        end
`ifdef GRF_BYPASS_EN
        if (we && (D_A2 == W_A3)) begin
            D_RD2 = W_WD;
        end
`endif
    end

    grf_commit_trace #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .pc      (W_PC),
        .addr    (W_A3),
        .data    (W_WD),
        .t_valid (T_Valid),
        .t_pc    (T_PC),
        .t_addr  (T_Addr),
        .t_data  (T_Data)
    );

endmodule

// File: tb/tb_w_stage_grf.sv
// Self-checking bench for w_stage_grf: vector table, trace scoreboard and reset/hazard sequences.
module tb_w_stage_grf;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] D_A1, D_A2, W_A3, T_Addr;
    logic [DW-1:0] D_RD1, D_RD2, W_WD, T_Data;
    logic [31:0]   W_PC, T_PC;
    logic          W_Valid, T_Valid;

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } tr_t;

    typedef struct {
        logic          v;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
        logic [31:0]   pc;
        logic [AW-1:0] rd;
    } vec_t;

    tr_t           sb[$];
    tr_t           tr_last;
    logic [DW-1:0] model [NR];
    logic          pend_we;
    logic [AW-1:0] pend_a3;
    logic [DW-1:0] pend_wd;
    int            errors = 0;
    int            checks = 0;
    vec_t          vecs [8];

    w_stage_grf dut (
        .clk     (clk),
        .reset   (reset),
        .D_A1    (D_A1),
        .D_A2    (D_A2),
        .D_RD1   (D_RD1),
        .D_RD2   (D_RD2),
        .W_A3    (W_A3),
        .W_WD    (W_WD),
        .W_PC    (W_PC),
        .W_Valid (W_Valid),
        .T_Valid (T_Valid),
        .T_PC    (T_PC),
        .T_Addr  (T_Addr),
        .T_Data  (T_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one W-stage slot and queue the trace it should produce.
    task automatic drive(input logic v, input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                         input logic [31:0] pc);
        tr_t exp;
        W_Valid = v;
        W_A3    = a3;
        W_WD    = wd;
        W_PC    = pc;
        pend_we = v && (a3 != '0);
        pend_a3 = a3;
        pend_wd = wd;
        if (pend_we) begin
            exp = '{valid: 1'b1, pc: pc, addr: a3, data: wd};
        end else begin
            exp = tr_last;
            exp.valid = 1'b0;
        end
        tr_last = exp;
        sb.push_back(exp);
    endtask

    task automatic finish_cycle(input string name);
        tr_t exp;
        @(posedge clk);
        #1;
        if (pend_we) model[pend_a3] = pend_wd;
        W_Valid = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
        end else begin
            exp = sb.pop_front();
            check({name, " T_Valid"}, 64'(T_Valid), 64'(exp.valid));
            check({name, " T_PC"},    64'(T_PC),    64'(exp.pc));
            check({name, " T_Addr"},  64'(T_Addr),  64'(exp.addr));
            check({name, " T_Data"},  64'(T_Data),  64'(exp.data));
        end
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] idx);
        D_A1 = idx;
        D_A2 = idx;
        #1;
        check({name, " D_RD1"}, 64'(D_RD1), 64'(model[idx]));
        check({name, " D_RD2"}, 64'(D_RD2), 64'(model[idx]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h3000, 5'd5};
        vecs[1] = '{1'b1, 5'd0,  32'h1234,     32'h3004, 5'd0};
        vecs[2] = '{1'b1, 5'd7,  32'h70,       32'h3008, 5'd7};
        vecs[3] = '{1'b0, 5'd7,  32'h7777,     32'h300C, 5'd7};
        vecs[4] = '{1'b1, 5'd31, 32'hA,        32'h3010, 5'd31};
        vecs[5] = '{1'b1, 5'd1,  32'hB,        32'h3014, 5'd1};
        vecs[6] = '{1'b1, 5'd31, 32'hC,        32'h3018, 5'd31};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        32'h301C, 5'd1};

        reset = 1'b1;
        W_Valid = 1'b0; W_A3 = '0; W_WD = '0; W_PC = '0;
        D_A1 = '0; D_A2 = '0;
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
        tr_last = '0;
        #1;
        check("reset T_Valid", 64'(T_Valid), 64'd0);
        check("reset T_PC",    64'(T_PC),    64'd0);
        check("reset T_Addr",  64'(T_Addr),  64'd0);
        check("reset T_Data",  64'(T_Data),  64'd0);
        for (int i = 0; i < int'(NR); i++) begin
            D_A1 = AW'(i);
            #1;
            check("reset D_RD1", 64'(D_RD1), 64'd0);
        end

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].a3, vecs[i].wd, vecs[i].pc);
            finish_cycle("vec");
            read_check("vec read", vecs[i].rd);
        end
        read_check("b2b r31", 5'd31);
        read_check("b2b r1", 5'd1);

        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 31));
            drive(1'b1, a, $urandom, 32'h4000 + 32'(i * 4));
            finish_cycle("rand");
            read_check("rand read", a);
        end

        // Same-cycle read/write to the same index.
        drive(1'b1, 5'd9, 32'h11, 32'h5000);
        finish_cycle("hz setup");
        read_check("hz setup read", 5'd9);
        drive(1'b1, 5'd9, 32'h22, 32'h5004);
        D_A1 = 5'd9;
        D_A2 = 5'd9;
        #1;
`ifdef GRF_BYPASS_EN
        check("hz pre D_RD1", 64'(D_RD1), 64'h22);
        check("hz pre D_RD2", 64'(D_RD2), 64'h22);
`else
        check("hz pre D_RD1", 64'(D_RD1), 64'h11);
        check("hz pre D_RD2", 64'(D_RD2), 64'h11);
`endif
        finish_cycle("hz");
        check("hz post D_RD1", 64'(D_RD1), 64'h22);
        check("hz post D_RD2", 64'(D_RD2), 64'h22);

        // Reset held across the edge of a pending write to index 4.
        drive(1'b1, 5'd4, 32'h55, 32'h6000);
        #1;
        reset = 1'b1;
        #1;
        check("rst T_Valid", 64'(T_Valid), 64'd0);
        check("rst T_PC",    64'(T_PC),    64'd0);
        check("rst T_Addr",  64'(T_Addr),  64'd0);
        check("rst T_Data",  64'(T_Data),  64'd0);
        D_A1 = 5'd5;
        #1;
        check("rst D_RD1 r5", 64'(D_RD1), 64'd0);
        @(posedge clk);
        #1;
        W_Valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
        tr_last = '0;
        D_A1 = 5'd4;
        #1;
        check("rst D_RD1 r4", 64'(D_RD1), 64'd0);
        check("rst T_Valid after", 64'(T_Valid), 64'd0);
        @(posedge clk);
        #1;
        check("idle T_Valid", 64'(T_Valid), 64'd0);

        drive(1'b1, 5'd4, 32'h66, 32'h6004);
        finish_cycle("post rst");
        read_check("post rst read", 5'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
